puf_crp_controller: RTL

Challenge-side driver for the 8-bit-challenge feed-forward arbiter PUF. It generates challenges with an LFSR and drives the challenge bus. For each challenge it resets the arbiter latches, fires the launch edge and samples the arbiter response. It packs RESP_BITS sampled responses into one response word for the host, UART or LED logic.

---
 rtl/puf_pkg.sv | 23 ++
 rtl/puf_crp_controller_if.sv | 41 ++++
 rtl/puf_lfsr8.sv | 28 ++
 rtl/puf_crp_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the arbiter-PUF challenge/response controller.
// Holds the FSM state enum, LFSR tap mask and zero-seed remap value.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    FIRE,
    SAMPLE,
    DONE
  } state_t;

  // x^8+x^6+x^5+x^4+1 as bit taps of a left-shifting register
  localparam logic [7:0] LFSR_TAPS  = 8'b1011_1000;
  localparam logic [7:0] SEED_REMAP = 8'h01;

  // An all-zero seed would lock the LFSR, so it is swapped for SEED_REMAP
  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == 8'h00) ? SEED_REMAP : s;
  endfunction

endpackage

// File: rtl/puf_crp_controller_if.sv
// Bundle between the CRP controller, the host and the PUF fabric.
// master = controller side; slave = host/PUF side.
interface puf_crp_controller_if #(
  parameter int RESP_BITS = 16
);

  logic                 start;
  logic [7:0]           seed;
  logic [7:0]           ch;
  logic                 launch;
  logic                 arb_rst;
  logic                 puf_resp;
  logic [RESP_BITS-1:0] resp_word;
  logic                 resp_valid;
  logic                 busy;

  modport master (
    input  start,
    input  seed,
    input  puf_resp,
    output ch,
    output launch,
    output arb_rst,
    output resp_word,
    output resp_valid,
    output busy
  );

  modport slave (
    output start,
    output seed,
    output puf_resp,
    input  ch,
    input  launch,
    input  arb_rst,
    input  resp_word,
    input  resp_valid,
    input  busy
  );

endinterface

// File: rtl/puf_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), shift left, feedback into bit 0.
// Ports: clk, rst (async active-low), load (take seed), step (advance), seed, q.
module puf_lfsr8
  import puf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic fb;

  assign fb = ^(q & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= seed_fix(seed);
    end else if (step) begin
      q <= {q[6:0], fb};
    end
  end

endmodule

// File: rtl/puf_crp_controller.sv
// Challenge-side driver for an 8-bit feed-forward arbiter PUF: LFSR challenges,
// arbiter clear/launch sequencing, and packing of RESP_BITS responses.
// Ports: clk, rst (async active-low), bus (puf_crp_controller_if.master):
//   start/seed in, ch/launch/arb_rst to PUF, puf_resp in (async),
//   resp_word/resp_valid/busy to host.
// Build option: define MAJORITY_VOTE_EN for VOTES evaluations per challenge.
module puf_crp_controller
  import puf_pkg::*;
#(
  parameter int RESP_BITS  = 16,
  parameter int SETTLE_CYC = 4,
  parameter int EVAL_CYC   = 8
`ifdef MAJORITY_VOTE_EN
  ,
  parameter int VOTES      = 5
`endif
) (
  input logic               clk,
  input logic               rst,
  puf_crp_controller_if.master bus
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] EVAL_LAST   = 16'(EVAL_CYC - 1);
  localparam logic [4:0]  IDX_LAST    = 5'(RESP_BITS - 1);
`ifdef MAJORITY_VOTE_EN
  localparam logic [3:0]  VOTE_LAST   = 4'(VOTES - 1);
  localparam logic [3:0]  VOTE_HALF   = 4'(VOTES / 2);
`endif

  state_t               state;
  state_t               state_n;
  logic [15:0]          cnt;
  logic [15:0]          cnt_n;
  logic [4:0]           idx;
  logic [4:0]           idx_n;
  logic [RESP_BITS-1:0] sr;
  logic [RESP_BITS-1:0] sr_n;
  logic [RESP_BITS-1:0] resp_q;
  logic                 resp_load;
  logic                 lfsr_load;
  logic                 lfsr_step;
  logic [7:0]           lfsr_q;
  logic                 sync1;
  logic                 resp_s;
  logic                 launch_q;
  logic                 arb_rst_q;
  logic                 busy_q;
  logic                 valid_q;
  logic                 bit_v;
  logic                 bit_done;
`ifdef MAJORITY_VOTE_EN
  logic [3:0]           vote_cnt;
  logic [3:0]           vote_cnt_n;
  logic [3:0]           vote_idx;
  logic [3:0]           vote_idx_n;
  logic [3:0]           ones;
`endif

  // The LFSR register is the challenge bus: it only moves on an accepted
  // start or after the final sample of a challenge, never while launch=1.
  puf_lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .step (lfsr_step),
    .seed (bus.seed),
    .q    (lfsr_q)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    sr_n      = sr;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    resp_load = 1'b0;
    bit_v     = resp_s;
    bit_done  = 1'b0;
`ifdef MAJORITY_VOTE_EN
    vote_cnt_n = vote_cnt;
    vote_idx_n = vote_idx;
    ones       = vote_cnt + {3'b000, resp_s};
`endif
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          lfsr_load = 1'b1;
          idx_n     = '0;
          sr_n      = '0;
          cnt_n     = '0;
          state_n   = LOAD;
        end
      end
      LOAD: begin
        cnt_n   = '0;
        state_n = SETTLE;
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_n   = '0;
          state_n = FIRE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      FIRE: begin
        if (cnt == EVAL_LAST) begin
          cnt_n   = '0;
          state_n = SAMPLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      SAMPLE: begin
`ifdef MAJORITY_VOTE_EN
        if (vote_idx == VOTE_LAST) begin
          bit_v      = (ones > VOTE_HALF);
          bit_done   = 1'b1;
          vote_cnt_n = '0;
          vote_idx_n = '0;
        end else begin
          // re-evaluate the same challenge: back to arbiter clear
          vote_cnt_n = ones;
          vote_idx_n = vote_idx + 4'd1;
          cnt_n      = '0;
          state_n    = SETTLE;
        end
`else
        bit_done = 1'b1;
`endif
        if (bit_done) begin
          lfsr_step = 1'b1;
          sr_n      = sr | (RESP_BITS'(bit_v) << idx);
          if (idx == IDX_LAST) begin
            resp_load = 1'b1;
            state_n   = DONE;
          end else begin
            idx_n   = idx + 5'd1;
            state_n = LOAD;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so the PUF fabric sees
  // glitch-free launch/clear lines aligned with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sr        <= '0;
      resp_q    <= '0;
      sync1     <= 1'b0;
      resp_s    <= 1'b0;
      launch_q  <= 1'b0;
      arb_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sr        <= sr_n;
      sync1     <= bus.puf_resp;
      resp_s    <= sync1;
      launch_q  <= (state_n == FIRE);
      arb_rst_q <= (state_n != FIRE);
      busy_q    <= state_n inside {LOAD, SETTLE, FIRE, SAMPLE};
      valid_q   <= (state_n == DONE);
      if (resp_load) begin
        resp_q <= sr_n;
      end
    end
  end

`ifdef MAJORITY_VOTE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vote_cnt <= '0;
      vote_idx <= '0;
    end else begin
      vote_cnt <= vote_cnt_n;
      vote_idx <= vote_idx_n;
    end
  end
`endif

  assign bus.ch         = lfsr_q;
  assign bus.launch     = launch_q;
  assign bus.arb_rst    = arb_rst_q;
  assign bus.busy       = busy_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_word  = resp_q;

endmodule
